ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- PS/2 keyboard receiver and decoder for the game input path; successor to the single-key PS/2 driver.
- Filters PS2_CLK and deserialises 11-bit frames with start, parity and stop checking, plus a frame timeout.
- Decodes E0 (extended) and F0 (break) prefixes.
- Keeps a table of up to NUM_KEYS simultaneously held keys, so movement and action keys can be combined.

Parameters:
NUM_KEYS, 4, number of held-key slots (1..8)
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered PS2_CLK level changes (2..15)
TIMEOUT_CYCLES, 50000, Clk cycles without a filtered falling edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
PS2_CLK  in  1  raw PS/2 clock from the keyboard
PS2_DAT  in  1  raw PS/2 data from the keyboard
key_valid  out  NUM_KEYS  slot i holds a pressed key
key_codes  out  9*NUM_KEYS  slot i is bits [9i+8:9i]; bit 8 is the extended (E0) flag, bits 7:0 are the scan code
keycode  out  8  low 8 bits of the lowest-index valid slot, else 8'h00 (backward-compatible output)
event_valid  out  1  one-cycle pulse for each decoded make or break
event_code  out  9  {ext, scancode} of the last event
event_make  out  1  1 = make, 0 = break; valid with event_valid
frame_err  out  1  one-cycle pulse when a frame is discarded
overflow  out  1  one-cycle pulse when a make finds no free slot

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs to 0;
  - the bit counter, decode FSM (to IDLE) and table;
  - the synchronisers and the filtered clock level, both to 1.
- Synchronisation: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser.
- Clock filter:
  - The filter counter counts consecutive synchronised samples that differ from the filtered level.
  - When the count reaches FILTER_LEN, the filtered level flips and the counter clears.
  - fall = filtered level goes 1->0, high for one cycle.
- Bit sampling:
  - On each fall, synchronised DAT is captured at bit index 0..10: 0 = start, 1..8 = data LSB first, 9 = odd parity, 10 = stop.
  - The counter returns to 0 after index 10.
- Frame check at index 10: the frame is good if start=0, the 8 data bits plus parity hold an odd number of 1s, and stop=1.
  - Bad frame: frame_err pulses, the byte is dropped and the FSM returns to IDLE.
- Timeout:
  - The timeout counter runs while the bit index is nonzero and resets on each fall.
  - At TIMEOUT_CYCLES: the bit index is cleared, frame_err pulses, the FSM goes to IDLE and the table is unchanged.
- Latency: if the stop bit is sampled on cycle N, then event_valid, event_code, event_make, table updates, overflow and frame_err are all registered and visible in cycle N+1.
- Decode FSM (states IDLE, EXT, BRK, EXT_BRK), for each good byte B:
  - IDLE: E0 -> EXT; F0 -> BRK.
  - EXT: F0 -> EXT_BRK.
  - Ignored bytes: 00, AA, E1, EE, FA, FC, FD, FE, FF produce no event and return the FSM to IDLE.
  - Any other B emits an event with ext = (state is EXT or EXT_BRK) and make = (state is IDLE or EXT), then the FSM returns to IDLE.
  - E0 or F0 received in a non-IDLE state (other than F0 in EXT) restarts the prefix as if received in IDLE.
  - Pause-key sequences are not supported: the bytes following E1 decode as ordinary codes.
- Table update:
  - Make of a code already held (typematic repeat): event pulses, table unchanged.
  - Make of a new code: written to the lowest-index free slot.
  - Make with all slots full: overflow pulses, event still pulses, code not stored.
  - Break of a held code: that slot's valid bit clears and its code is zeroed.
  - Break of an absent code: event pulses, table unchanged.
  - Slots are never compacted.
- Simultaneous timeout and fall in the same cycle: the fall wins and the timeout counter resets.
- Reset mid-frame: everything clears and reception resumes at the next start bit.

Test Plan:
- Reset low mid-frame, then high -> all outputs 0; the next frame 1C decodes normally (event_code=01C, make=1, slot0=01C, keycode=1C).
- Frames 1D, 1C, 23, 1B in sequence -> slots 0..3 = 01D, 01C, 023, 01B, key_valid=4'hF; then 2B -> overflow pulse, event 02B make, table unchanged.
- With slots 0..3 full: F0,1C -> slot1 cleared, key_valid=4'b1101, keycode=1D; then 2B -> stored in slot1.
- Frames E0,75 then E0,F0,75 -> make event 175 with slot0=175 and keycode=75, then break event 175 with slot0 cleared.
- 1C sent with wrong parity, then stop=0, then start=1 -> frame_err each time, no event, FSM in IDLE; and 1C repeated twice -> two events, one slot.
- Send 5 bits then idle for TIMEOUT_CYCLES -> frame_err pulse; the following full 1C frame decodes; a 1-sample PS2_CLK glitch with FILTER_LEN=4 -> no bit counted.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// ============================================================================
// Module  : ps2_key_tracker_if
// Purpose : PS/2 line inputs and decoded key-table outputs of ps2_key_tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_key_tracker_if #(
  parameter int NUM_KEYS = 4
);
  logic                    PS2_CLK;
  logic                    PS2_DAT;
  logic [NUM_KEYS-1:0]     key_valid;
  logic [9*NUM_KEYS-1:0]   key_codes;
  logic [7:0]              keycode;
  logic                    event_valid;
  logic [8:0]              event_code;
  logic                    event_make;
  logic                    frame_err;
  logic                    overflow;

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output key_valid, key_codes, keycode, event_valid, event_code,
           event_make, frame_err, overflow
  );

  modport master (
    output PS2_CLK, PS2_DAT,
    input  key_valid, key_codes, keycode, event_valid, event_code,
           event_make, frame_err, overflow
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module  : ps2_key_tracker
// Purpose : PS/2 receiver with E0/F0 prefix decode and a multi-key held table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_tracker #(
  parameter int NUM_KEYS       = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic           Clk,
  input  wire logic           Reset_n,
  ps2_key_tracker_if.slave    bus
);
  localparam int          c_TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  c_FLT_LAST = 4'(FILTER_LEN - 1);

  // bit 0 = extended, bit 1 = break: event flags fall straight out of the state
  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_EXT     = 2'b01;
  localparam logic [1:0] S_BRK     = 2'b10;
  localparam logic [1:0] S_EXT_BRK = 2'b11;

  logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic              filt_q, filt_d, fall_q, fall_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [9:0]        shift_q, shift_d;
  logic [c_TW-1:0]   tcnt_q, tcnt_d;
  logic [1:0]        state_q, state_d;
  logic              byte_ok, frame_bad, timeout;
  logic [7:0]        rx_byte;
  logic              ev_d, ev_make_d, ovf_d;
  logic [8:0]        ev_code_d;
  logic              ev_q, ev_make_q, ovf_q, ferr_q;
  logic [8:0]        ev_code_q;
  logic [NUM_KEYS-1:0] valid_q, valid_d;
  logic [8:0]        codes_q [NUM_KEYS];
  logic [8:0]        codes_d [NUM_KEYS];
  logic              hit, placed;
  logic [7:0]        keycode_w;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == c_FLT_LAST) filt_d = ~filt_q;
      else                      fcnt_d = fcnt_q + 4'd1;
    end
    fall_d = filt_q & ~filt_d;
  end

  // A fall in the same cycle as timeout expiry takes priority and restarts the count
  always_comb begin
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    tcnt_d    = '0;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    if (fall_q) begin
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = '0;
        if (!shift_q[0] && (^shift_q[9:1]) && dat_s2_q) byte_ok = 1'b1;
        else                                            frame_bad = 1'b1;
      end else begin
        shift_d[bitcnt_q] = dat_s2_q;
        bitcnt_d          = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != '0) begin
      if (tcnt_q == c_TO_LAST) begin
        timeout  = 1'b1;
        bitcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  assign rx_byte = shift_q[8:1];

  always_comb begin
    state_d   = state_q;
    ev_d      = 1'b0;
    ev_make_d = ~state_q[1];
    ev_code_d = {state_q[0], rx_byte};
    if (frame_bad || timeout) begin
      state_d = S_IDLE;
    end else if (byte_ok) begin
      case (rx_byte)
        8'hE0: state_d = S_EXT;
        8'hF0: state_d = (state_q == S_EXT) ? S_EXT_BRK : S_BRK;
        8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
        8'hFC, 8'hFD, 8'hFE, 8'hFF: state_d = S_IDLE;
        default: begin
          ev_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    codes_d = codes_q;
    hit     = 1'b0;
    placed  = 1'b0;
    ovf_d   = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (valid_q[i] && codes_q[i] == ev_code_d) hit = 1'b1;
    if (ev_d && ev_make_d && !hit) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!placed && !valid_q[i]) begin
          valid_d[i] = 1'b1;
          codes_d[i] = ev_code_d;
          placed     = 1'b1;
        end
      end
      ovf_d = ~placed;
    end else if (ev_d && !ev_make_d) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (valid_q[i] && codes_q[i] == ev_code_d) begin
          valid_d[i] = 1'b0;
          codes_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      tcnt_q    <= '0;
      state_q   <= S_IDLE;
      ev_q      <= 1'b0;
      ev_make_q <= 1'b0;
      ev_code_q <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) codes_q[i] <= '0;
    end else begin
      clk_s1_q  <= bus.PS2_CLK;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= bus.PS2_DAT;
      dat_s2_q  <= dat_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      tcnt_q    <= tcnt_d;
      state_q   <= state_d;
      ev_q      <= ev_d;
      ovf_q     <= ovf_d;
      ferr_q    <= frame_bad | timeout;
      valid_q   <= valid_d;
      codes_q   <= codes_d;
      if (ev_d) begin
        ev_make_q <= ev_make_d;
        ev_code_q <= ev_code_d;
      end
    end
  end

  always_comb begin
    keycode_w = 8'h00;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (valid_q[i]) keycode_w = codes_q[i][7:0];
  end

  generate
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_pack
      assign bus.key_codes[9*g +: 9] = codes_q[g];
    end
  endgenerate

  assign bus.key_valid   = valid_q;
  assign bus.keycode     = keycode_w;
  assign bus.event_valid = ev_q;
  assign bus.event_code  = ev_code_q;
  assign bus.event_make  = ev_make_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
// ============================================================================
// Module  : tb_ps2_key_tracker
// Purpose : Directed bench for ps2_key_tracker: framing, prefixes, key table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_tracker;
  localparam int NUM_KEYS       = 4;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 200;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   ev_cnt = 0, err_cnt = 0, ov_cnt = 0;
  logic [8:0] last_code = '0;
  logic       last_make = 1'b0;

  ps2_key_tracker_if #(.NUM_KEYS(NUM_KEYS)) bus ();

  ps2_key_tracker #(
    .NUM_KEYS(NUM_KEYS), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (bus.event_valid === 1'b1) begin
      ev_cnt++;
      last_code = bus.event_code;
      last_make = bus.event_make;
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.overflow === 1'b1)  ov_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.PS2_DAT = b;
    wait_clk(4);
    bus.PS2_CLK = 1'b0;
    wait_clk(8);
    bus.PS2_CLK = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_frame(input logic st, input logic [7:0] b, input logic par, input logic sp);
    send_bit(st);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(sp);
    bus.PS2_DAT = 1'b1;
    wait_clk(20);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(1'b0, b, ~^b, 1'b1);
  endtask

  task automatic test_reset;
    int e0;
    send_byte(8'h1D);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    Reset_n = 1'b0;
    wait_clk(3);
    checks++; if (bus.key_valid !== 4'h0) begin errors++; $display("FAIL rst_key_valid: got %h want 0", bus.key_valid); end
    checks++; if (bus.key_codes !== 36'h0) begin errors++; $display("FAIL rst_key_codes: got %h want 0", bus.key_codes); end
    checks++; if (bus.keycode !== 8'h00) begin errors++; $display("FAIL rst_keycode: got %h want 0", bus.keycode); end
    checks++; if ({bus.event_valid, bus.event_make, bus.frame_err, bus.overflow} !== 4'b0)
      begin errors++; $display("FAIL rst_flags: got %b want 0000", {bus.event_valid, bus.event_make, bus.frame_err, bus.overflow}); end
    checks++; if (bus.event_code !== 9'h000) begin errors++; $display("FAIL rst_event_code: got %h want 000", bus.event_code); end
    Reset_n = 1'b1;
    wait_clk(5);
    e0 = ev_cnt;
    send_byte(8'h1C);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL rst_next_ev: got %0d want 1", ev_cnt - e0); end
    checks++; if ({last_code, last_make} !== {9'h01C, 1'b1}) begin errors++; $display("FAIL rst_next_code: got %h/%b want 01C/1", last_code, last_make); end
    checks++; if (bus.key_codes[8:0] !== 9'h01C) begin errors++; $display("FAIL rst_next_slot0: got %h want 01C", bus.key_codes[8:0]); end
    checks++; if (bus.keycode !== 8'h1C) begin errors++; $display("FAIL rst_next_keycode: got %h want 1C", bus.keycode); end
    checks++; if (bus.key_valid !== 4'b0001) begin errors++; $display("FAIL rst_next_valid: got %b want 0001", bus.key_valid); end
  endtask

  task automatic test_fill_overflow;
    int e0, o0;
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (bus.key_valid !== 4'h0) begin errors++; $display("FAIL fill_pre_empty: got %b want 0000", bus.key_valid); end
    send_byte(8'h1D); send_byte(8'h1C); send_byte(8'h23); send_byte(8'h1B);
    checks++; if (bus.key_codes !== {9'h01B, 9'h023, 9'h01C, 9'h01D}) begin errors++; $display("FAIL fill_codes: got %h want %h", bus.key_codes, {9'h01B, 9'h023, 9'h01C, 9'h01D}); end
    checks++; if (bus.key_valid !== 4'hF) begin errors++; $display("FAIL fill_valid: got %b want 1111", bus.key_valid); end
    checks++; if (bus.keycode !== 8'h1D) begin errors++; $display("FAIL fill_keycode: got %h want 1D", bus.keycode); end
    e0 = ev_cnt; o0 = ov_cnt;
    send_byte(8'h2B);
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d want 1", ov_cnt - o0); end
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL ovf_event: got %0d want 1", ev_cnt - e0); end
    checks++; if ({last_code, last_make} !== {9'h02B, 1'b1}) begin errors++; $display("FAIL ovf_code: got %h/%b want 02B/1", last_code, last_make); end
    checks++; if (bus.key_codes !== {9'h01B, 9'h023, 9'h01C, 9'h01D}) begin errors++; $display("FAIL ovf_table: got %h", bus.key_codes); end
  endtask

  task automatic test_break_reuse;
    int o0;
    o0 = ov_cnt;
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if ({last_code, last_make} !== {9'h01C, 1'b0}) begin errors++; $display("FAIL brk_code: got %h/%b want 01C/0", last_code, last_make); end
    checks++; if (bus.key_valid !== 4'b1101) begin errors++; $display("FAIL brk_valid: got %b want 1101", bus.key_valid); end
    checks++; if (bus.key_codes[17:9] !== 9'h000) begin errors++; $display("FAIL brk_slot1: got %h want 000", bus.key_codes[17:9]); end
    checks++; if (bus.keycode !== 8'h1D) begin errors++; $display("FAIL brk_keycode: got %h want 1D", bus.keycode); end
    send_byte(8'h2B);
    checks++; if (bus.key_codes[17:9] !== 9'h02B) begin errors++; $display("FAIL reuse_slot1: got %h want 02B", bus.key_codes[17:9]); end
    checks++; if (bus.key_valid !== 4'hF || ov_cnt !== o0) begin errors++; $display("FAIL reuse_valid: got %b/%0d want 1111/%0d", bus.key_valid, ov_cnt, o0); end
    send_byte(8'hF0); send_byte(8'h1D);
    checks++; if (bus.keycode !== 8'h2B) begin errors++; $display("FAIL brk0_keycode: got %h want 2B", bus.keycode); end
    send_byte(8'hF0); send_byte(8'h2B);
    send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h1B);
    checks++; if (bus.key_valid !== 4'h0 || bus.key_codes !== 36'h0) begin errors++; $display("FAIL clear_all: got %b/%h want 0/0", bus.key_valid, bus.key_codes); end
  endtask

  task automatic test_extended;
    int e0;
    send_byte(8'hE0); send_byte(8'h75);
    checks++; if ({last_code, last_make} !== {9'h175, 1'b1}) begin errors++; $display("FAIL ext_make: got %h/%b want 175/1", last_code, last_make); end
    checks++; if (bus.key_codes[8:0] !== 9'h175 || bus.keycode !== 8'h75) begin errors++; $display("FAIL ext_slot0: got %h/%h want 175/75", bus.key_codes[8:0], bus.keycode); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++; if ({last_code, last_make} !== {9'h175, 1'b0}) begin errors++; $display("FAIL ext_break: got %h/%b want 175/0", last_code, last_make); end
    checks++; if (bus.key_valid !== 4'h0 || bus.key_codes[8:0] !== 9'h000) begin errors++; $display("FAIL ext_cleared: got %b/%h want 0/000", bus.key_valid, bus.key_codes[8:0]); end
    e0 = ev_cnt;
    send_byte(8'hAA);
    checks++; if (ev_cnt !== e0) begin errors++; $display("FAIL ignored_AA: got %0d events want 0", ev_cnt - e0); end
    send_byte(8'hF0); send_byte(8'h33);
    checks++; if (ev_cnt - e0 !== 1 || last_code !== 9'h033 || last_make !== 1'b0 || bus.key_valid !== 4'h0)
      begin errors++; $display("FAIL absent_break: got ev=%0d %h/%b valid=%b want 1 033/0 0", ev_cnt - e0, last_code, last_make, bus.key_valid); end
  endtask

  task automatic test_frame_errors;
    int e0, f0;
    e0 = ev_cnt; f0 = err_cnt;
    send_frame(1'b0, 8'h1C, ^8'h1C, 1'b1);
    checks++; if (err_cnt - f0 !== 1) begin errors++; $display("FAIL err_parity: got %0d want 1", err_cnt - f0); end
    send_frame(1'b0, 8'h1C, ~^8'h1C, 1'b0);
    checks++; if (err_cnt - f0 !== 2) begin errors++; $display("FAIL err_stop: got %0d want 2", err_cnt - f0); end
    send_frame(1'b1, 8'h1C, ~^8'h1C, 1'b1);
    checks++; if (err_cnt - f0 !== 3) begin errors++; $display("FAIL err_start: got %0d want 3", err_cnt - f0); end
    checks++; if (ev_cnt !== e0) begin errors++; $display("FAIL err_no_event: got %0d want 0", ev_cnt - e0); end
    send_byte(8'hF0);
    send_frame(1'b0, 8'h1C, ^8'h1C, 1'b1);
    send_byte(8'h1C);
    checks++; if ({last_code, last_make} !== {9'h01C, 1'b1}) begin errors++; $display("FAIL err_fsm_idle: got %h/%b want 01C/1", last_code, last_make); end
    send_byte(8'h1C);
    checks++; if (ev_cnt - e0 !== 2) begin errors++; $display("FAIL repeat_events: got %0d want 2", ev_cnt - e0); end
    checks++; if (bus.key_valid !== 4'b0001 || bus.key_codes !== 36'h01C) begin errors++; $display("FAIL repeat_one_slot: got %b/%h want 0001/01C", bus.key_valid, bus.key_codes); end
  endtask

  task automatic test_timeout_glitch;
    int e0, f0;
    e0 = ev_cnt; f0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_clk(TIMEOUT_CYCLES + 50);
    checks++; if (err_cnt - f0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d want 1", err_cnt - f0); end
    checks++; if (ev_cnt !== e0 || bus.key_valid !== 4'b0001) begin errors++; $display("FAIL timeout_table: got ev=%0d valid=%b want 0/0001", ev_cnt - e0, bus.key_valid); end
    send_byte(8'h1C);
    checks++; if (ev_cnt - e0 !== 1 || last_code !== 9'h01C || last_make !== 1'b1) begin errors++; $display("FAIL timeout_next: got ev=%0d %h/%b want 1 01C/1", ev_cnt - e0, last_code, last_make); end
    bus.PS2_CLK = 1'b0;
    wait_clk(1);
    bus.PS2_CLK = 1'b1;
    wait_clk(20);
    send_byte(8'h1D);
    checks++; if (err_cnt - f0 !== 1 || last_code !== 9'h01D || last_make !== 1'b1) begin errors++; $display("FAIL glitch_frame: got err=%0d %h/%b want 1 01D/1", err_cnt - f0, last_code, last_make); end
    checks++; if (bus.key_valid !== 4'b0011 || bus.key_codes[17:9] !== 9'h01D) begin errors++; $display("FAIL glitch_slot1: got %b/%h want 0011/01D", bus.key_valid, bus.key_codes[17:9]); end
  endtask

  initial begin
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    Reset_n = 1'b0;
    wait_clk(4);
    Reset_n = 1'b1;
    wait_clk(4);
    test_reset;
    test_fill_overflow;
    test_break_reuse;
    test_extended;
    test_frame_errors;
    test_timeout_glitch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
